aes_v3_enc: RTL and testbench

// - AES-128 encryption core (FIPS-197, 10 rounds), one block at a time, byte-serial S-box.
// - S-box is an external 256x8 ROM with 1-cycle synchronous read: rom_data(t+1) = SBOX[rom_addr(t)].
// - No start/valid input: the core samples plaintext/key on the first edge after reset release,
//   and again on the second edge after each done pulse; inputs are undefined at all other times.

---
 rtl/aes_v3_pkg.sv | 48 ++++
 rtl/aes_v3_mixcol.sv | 21 ++
 rtl/aes_v3_enc.sv | 144 ++++++++++++++
 tb/tb_aes_v3_enc.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_v3_pkg.sv
// AES-128 encrypt core: shared types, Rcon table and byte helpers.
// Optional feature macro used by the top: AES_V3_BUSY_EN.
package aes_v3_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SUB,
    S_MIX,
    S_DONE
  } state_t;

  localparam logic [79:0] RCON_TBL =
    80'h01020408102040801b36;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^
           (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    return RCON_TBL[79 - 8*(int'(r) - 1) -: 8];
  endfunction

  // byte i lives at bits [127-8i -: 8]
  function automatic logic [7:0] get_b(
    input logic [127:0] v,
    input int           i
  );
    return v[127 - 8*i -: 8];
  endfunction

  // ShiftRows: dest byte i takes row r, col (c+r)%4
  function automatic int sr_src(input int i);
    return (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
  endfunction

  // RotWord(w3) byte order: 13,14,15,12
  function automatic int rot_idx(input int c);
    return 12 + ((c + 1) % 4);
  endfunction

endpackage

// File: rtl/aes_v3_mixcol.sv
// MixColumns of one column; col/mixed = {row0,row1,row2,row3}.
// Ports: col (in, 32), mixed (out, 32). Purely combinational.
module aes_v3_mixcol
  import aes_v3_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col;

  assign mixed = {
    xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
  };

endmodule

// File: rtl/aes_v3_enc.sv
// AES-128 encrypt, byte-serial S-box via external sync ROM.
// Ports: clk, rst (async low), plaintext, key, rom_data in;
// rom_addr, ciphertext, done (+busy if AES_V3_BUSY_EN) out.
module aes_v3_enc
  import aes_v3_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  input  logic [7:0]   rom_data,
  output logic [7:0]   rom_addr,
  output logic [127:0] ciphertext,
  output logic         done
`ifdef AES_V3_BUSY_EN
  ,
  output logic         busy
`endif
);

  state_t       state, state_nx;
  logic [4:0]   cnt, cnt_n;
  logic [3:0]   round;
  logic [127:0] st, rk;
  logic [31:0]  tmp;
  logic [127:0] sr, mc, rk_nx, mix_out;
  logic [31:0]  temp, w0, w1, w2, w3;
  logic [7:0]   sub_addr;

  always_comb begin
    sr = '0;
    for (int i = 0; i < 16; i++)
      sr[127 - 8*i -: 8] = get_b(st, sr_src(i));
  end

  for (genvar j = 0; j < 4; j++) begin : g_mc
    aes_v3_mixcol u_mc (
      .col   (sr[127 - 32*j -: 32]),
      .mixed (mc[127 - 32*j -: 32])
    );
  end

  assign temp    = tmp ^ {rcon(round), 24'h0};
  assign w0      = rk[127:96] ^ temp;
  assign w1      = rk[95:64]  ^ w0;
  assign w2      = rk[63:32]  ^ w1;
  assign w3      = rk[31:0]   ^ w2;
  assign rk_nx   = {w0, w1, w2, w3};
  assign mix_out = ((round == NR) ? sr : mc) ^ rk_nx;

  // ROM address for the next SUB cycle
  assign cnt_n = cnt + 5'd1;

  always_comb begin
    sub_addr = 8'h00;
    unique case (1'b1)
      (cnt_n <= 5'd3):
        sub_addr = get_b(rk, rot_idx(int'(cnt_n)));
      (cnt_n >= 5'd4 && cnt_n <= 5'd19):
        sub_addr = get_b(st, int'(cnt_n) - 4);
      default:
        sub_addr = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD: state_nx = S_SUB;
      S_SUB:
        if (cnt == 5'd20) state_nx = S_MIX;
      S_MIX:
        state_nx = (round == NR) ? S_DONE : S_SUB;
      S_DONE: state_nx = S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      round      <= '0;
      st         <= '0;
      rk         <= '0;
      tmp        <= '0;
      rom_addr   <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          st       <= plaintext ^ key;
          rk       <= key;
          round    <= 4'd1;
          cnt      <= '0;
          rom_addr <= get_b(key, rot_idx(0));
        end
        S_SUB: begin
          cnt      <= cnt_n;
          rom_addr <= sub_addr;
          // capture lags the address by one cycle
          if (cnt >= 5'd1 && cnt <= 5'd4)
            tmp[31 - 8*(int'(cnt) - 1) -: 8] <= rom_data;
          else if (cnt >= 5'd5)
            st[127 - 8*(int'(cnt) - 5) -: 8] <= rom_data;
        end
        S_MIX: begin
          rk  <= rk_nx;
          st  <= mix_out;
          cnt <= '0;
          if (round == NR) begin
            ciphertext <= mix_out;
            done       <= 1'b1;
            rom_addr   <= 8'h00;
          end else begin
            round    <= round + 4'd1;
            rom_addr <= get_b(rk_nx, rot_idx(0));
          end
        end
        S_DONE: begin
          done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_V3_BUSY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy <= 1'b0;
    else if (state == S_LOAD)
      busy <= 1'b1;
    else if (state == S_MIX && round == NR)
      busy <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_aes_v3_enc.sv
// Testbench for aes_v3_enc: FIPS vectors, ROM protocol,
// back-to-back blocks, reset abort, optional busy.
module tb_aes_v3_enc;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] plaintext = 'x;
  logic [127:0] key = 'x;
  logic [7:0]   rom_data;
  logic [7:0]   rom_addr;
  logic [127:0] ciphertext;
  logic         done;
  logic [7:0]   rom_q;
  logic         cap_win = 1'b0;
  bit           xmode = 1'b0;
`ifdef AES_V3_BUSY_EN
  logic         busy;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] sbox [256];

  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [79:0] RC = 80'h01020408102040801b36;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_v3_enc u_dut (
    .clk        (clk),
    .rst        (rst),
    .plaintext  (plaintext),
    .key        (key),
    .rom_data   (rom_data),
    .rom_addr   (rom_addr),
    .ciphertext (ciphertext),
    .done       (done)
`ifdef AES_V3_BUSY_EN
    ,
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= sbox[rom_addr];

  assign rom_data = (xmode && !cap_win) ? 8'hxx : rom_q;

  function automatic logic [7:0] gb(
    input logic [127:0] v,
    input int           i
  );
    return v[127 - 8*i -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] key_step(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] t, a, b, c, d;
    t = {sbox[gb(k, 13)] ^ rc, sbox[gb(k, 14)],
         sbox[gb(k, 15)], sbox[gb(k, 12)]};
    a = k[127:96] ^ t;
    b = k[95:64] ^ a;
    c = k[63:32] ^ b;
    d = k[31:0] ^ c;
    return {a, b, c, d};
  endfunction

  function automatic logic [127:0] enc_round(
    input logic [127:0] s,
    input logic [127:0] k,
    input bit           last
  );
    logic [7:0]   b [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      int r, c;
      r = i % 4;
      c = i / 4;
      b[i] = sbox[gb(s, r + 4*((c + r) % 4))];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = b[4*c];
      a1 = b[4*c+1];
      a2 = b[4*c+2];
      a3 = b[4*c+3];
      if (last)
        o[127 - 32*c -: 32] = {a0, a1, a2, a3};
      else
        o[127 - 32*c -: 32] = {
          xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
          a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
          a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
          xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ k;
  endfunction

  // Drives one block at the next edge (the sampling edge) and
  // checks every cycle up to the DONE cycle.
  task automatic run_block(
    input logic [127:0] pt,
    input logic [127:0] k,
    input logic [127:0] exp_ct,
    input logic [127:0] prev_ct,
    input string        nm
  );
    logic [127:0] rks [11];
    logic [127:0] sts [11];
    logic [7:0]   ea;
    int           c, r;
    rks[0] = k;
    sts[0] = pt ^ k;
    for (int i = 1; i <= 10; i++) begin
      rks[i] = key_step(rks[i-1], RC[79 - 8*(i-1) -: 8]);
      sts[i] = enc_round(sts[i-1], rks[i], i == 10);
    end
    plaintext = pt;
    key       = k;
    cap_win   = 1'b0;
    @(posedge clk);
    #1;
    plaintext = 'x;
    key       = 'x;
    for (int t = 0; t < 222; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      c = t % 22;
      r = t / 22 + 1;
      cap_win = (t < 220) && (c >= 1) && (c <= 20);
      if (t >= 220 || c >= 20) ea = 8'h00;
      else if (c < 4) ea = gb(rks[r-1], 12 + ((c + 1) % 4));
      else ea = gb(sts[r-1], c - 4);
      checks++;
      if (rom_addr !== ea) begin
        failures++;
        $display("FAIL %s rom_addr t=%0d got=%h exp=%h",
                 nm, t, rom_addr, ea);
      end
      checks++;
      if (done !== (t == 220)) begin
        failures++;
        $display("FAIL %s done t=%0d got=%b exp=%b",
                 nm, t, done, (t == 220));
      end
      checks++;
      if (ciphertext !== ((t < 220) ? prev_ct : exp_ct)) begin
        failures++;
        $display("FAIL %s ciphertext t=%0d got=%h exp=%h", nm, t,
                 ciphertext, (t < 220) ? prev_ct : exp_ct);
      end
`ifdef AES_V3_BUSY_EN
      checks++;
      if (busy !== (t < 220)) begin
        failures++;
        $display("FAIL %s busy t=%0d got=%b exp=%b",
                 nm, t, busy, (t < 220));
      end
`endif
    end
    cap_win = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (ciphertext !== 128'h0) begin
      failures++;
      $display("FAIL %s ciphertext got=%h exp=0", nm, ciphertext);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done got=%b exp=0", nm, done);
    end
    checks++;
    if (rom_addr !== 8'h00) begin
      failures++;
      $display("FAIL %s rom_addr got=%h exp=00", nm, rom_addr);
    end
`ifdef AES_V3_BUSY_EN
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy got=%b exp=0", nm, busy);
    end
`endif
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("reset_release");
  endtask

  task automatic test_vec1;
    xmode = 1'b0;
    run_block(PT1, K1, CT1, 128'h0, "vec1");
  endtask

  task automatic test_rom_x;
    xmode = 1'b1;
    run_block(PT2, K2, CT2, CT1, "vec2_romx");
  endtask

  task automatic test_back_to_back;
    xmode = 1'b1;
    run_block(128'h0, 128'h0, CT3, CT2, "b2b_zero");
    run_block(PT1, K1, CT1, CT3, "b2b_vec1");
    xmode = 1'b0;
    run_block(PT2, K2, CT2, CT1, "b2b_vec2");
  endtask

  task automatic test_reset_abort;
    xmode     = 1'b0;
    plaintext = PT2;
    key       = K2;
    @(posedge clk);
    #1;
    plaintext = 'x;
    key       = 'x;
    repeat (4*22 + 5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_idle("abort_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_block(PT1, K1, CT1, 128'h0, "abort_vec1");
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      sbox[i] = SBOX_HEX[2047 - 8*i -: 8];
    test_reset();
    test_vec1();
    test_rom_x();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
